// File: rtl/video_window_framer_pkg.sv
// Shared defaults, FSM state encoding and output address layout for the video window framer.
package video_window_framer_pkg;

    localparam int unsigned DefHStart  = 140;
    localparam int unsigned DefHActive = 702;
    localparam int unsigned DefVStart  = 22;
    localparam int unsigned DefVActive = 288;

    localparam int unsigned ColW  = 10;
    localparam int unsigned RowW  = 9;
    localparam int unsigned SkipW = 10;
    localparam int unsigned AddrW = 20;

    // Address layout: row [19:11], field [10], col [9:0].
    localparam int unsigned AddrRowLsb   = 11;
    localparam int unsigned AddrFieldBit = 10;
    localparam int unsigned AddrColLsb   = 0;

    typedef enum logic [2:0] {
        StIdle,
        StVBlank,
        StHBlank,
        StActive,
        StLineEnd
    } state_e;

    function automatic logic [AddrW-1:0] pack_addr(
        input logic [RowW-1:0] row,
        input logic            fld,
        input logic [ColW-1:0] col
    );
        logic [AddrW-1:0] a;
        a = '0;
        a[AddrRowLsb +: RowW] = row;
        a[AddrFieldBit]       = fld;
        a[AddrColLsb +: ColW] = col;
        return a;
    endfunction

endpackage

// File: rtl/video_window_framer.sv
// Extracts the active window from a decoded video stream and tags every active pixel
// with a {row, field, col} address; all outputs are registered one cycle after the input.
module video_window_framer
    import video_window_framer_pkg::*;
#(
    parameter int unsigned H_START  = DefHStart,
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned V_START  = DefVStart,
    parameter int unsigned V_ACTIVE = DefVActive
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [7:0]       pix_data,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             field,
    output logic             video_frame_valid,
    output logic             video_line_valid,
    output logic             video_data_valid,
    output logic [7:0]       video_data,
    output logic [AddrW-1:0] video_address,
    output logic             line_err,
    output logic             frame_err
);

    localparam logic [SkipW-1:0] HStartLast  = SkipW'(H_START - 1);
    localparam logic [SkipW-1:0] VStartLast  = SkipW'(V_START - 1);
    localparam logic [ColW-1:0]  HActiveLast = ColW'(H_ACTIVE - 1);
    localparam logic [RowW-1:0]  VActiveLast = RowW'(V_ACTIVE - 1);

    state_e            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [SkipW-1:0]  hskip_q, hskip_d;
    logic [SkipW-1:0]  vskip_q, vskip_d;
    logic              field_q, field_d;
    logic              frame_valid_q, frame_valid_d;
    logic              line_valid_q, line_valid_d;
    logic              data_valid_q, data_valid_d;
    logic [7:0]        data_q, data_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic              line_err_q, line_err_d;
    logic              frame_err_q, frame_err_d;
    logic              end_line;

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        hskip_d       = hskip_q;
        vskip_d       = vskip_q;
        field_d       = field_q;
        frame_valid_d = frame_valid_q;
        line_valid_d  = line_valid_q;
        data_valid_d  = 1'b0;
        data_d        = data_q;
        addr_d        = addr_q;
        line_err_d    = 1'b0;
        frame_err_d   = 1'b0;
        end_line      = 1'b0;

        if (vsync) begin
            // vsync wins over everything; a field still being output is truncated.
            state_d       = StVBlank;
            row_d         = '0;
            col_d         = '0;
            hskip_d       = '0;
            vskip_d       = '0;
            field_d       = field;
            frame_err_d   = frame_valid_q;
            frame_valid_d = 1'b0;
            line_valid_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StVBlank: begin
                    if (hsync) begin
                        if (vskip_q == VStartLast) begin
                            state_d = StHBlank;
                            row_d   = '0;
                            hskip_d = '0;
                            vskip_d = '0;
                        end else begin
                            vskip_d = vskip_q + SkipW'(1);
                        end
                    end
                end
                StHBlank: begin
                    if (hsync) begin
                        line_err_d = 1'b1;
                        end_line   = 1'b1;
                    end else if (pix_valid) begin
                        if (hskip_q == HStartLast) begin
                            state_d       = StActive;
                            col_d         = '0;
                            hskip_d       = '0;
                            line_valid_d  = 1'b1;
                            frame_valid_d = 1'b1;
                        end else begin
                            hskip_d = hskip_q + SkipW'(1);
                        end
                    end
                end
                StActive: begin
                    if (hsync) begin
                        line_err_d = 1'b1;
                        end_line   = 1'b1;
                    end else if (pix_valid) begin
                        data_valid_d = 1'b1;
                        data_d       = pix_data;
                        addr_d       = pack_addr(row_q, field_q, col_q);
                        if (col_q == HActiveLast) begin
                            state_d = StLineEnd;
                        end else begin
                            col_d = col_q + ColW'(1);
                        end
                    end
                end
                StLineEnd: begin
                    if (hsync) begin
                        end_line = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Line termination, normal or short: the last row closes the field.
            if (end_line) begin
                line_valid_d = 1'b0;
                col_d        = '0;
                hskip_d      = '0;
                if (row_q == VActiveLast) begin
                    state_d       = StIdle;
                    frame_valid_d = 1'b0;
                end else begin
                    state_d = StHBlank;
                    row_d   = row_q + RowW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_q         <= '0;
            hskip_q       <= '0;
            vskip_q       <= '0;
            field_q       <= 1'b0;
            frame_valid_q <= 1'b0;
            line_valid_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            data_q        <= '0;
            addr_q        <= '0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hskip_q       <= hskip_d;
            vskip_q       <= vskip_d;
            field_q       <= field_d;
            frame_valid_q <= frame_valid_d;
            line_valid_q  <= line_valid_d;
            data_valid_q  <= data_valid_d;
            data_q        <= data_d;
            addr_q        <= addr_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign video_frame_valid = frame_valid_q;
    assign video_line_valid  = line_valid_q;
    assign video_data_valid  = data_valid_q;
    assign video_data        = data_q;
    assign video_address     = addr_q;
    assign line_err          = line_err_q;
    assign frame_err         = frame_err_q;

endmodule

// File: tb/tb_video_window_framer.sv
// Scoreboard bench for video_window_framer: drivers push expected pixels, a negedge
// monitor pops and compares every data_valid beat.
module tb_video_window_framer;

    localparam int HS = 4;
    localparam int HA = 8;
    localparam int VS = 2;
    localparam int VA = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        field = 1'b0;
    logic        video_frame_valid;
    logic        video_line_valid;
    logic        video_data_valid;
    logic [7:0]  video_data;
    logic [19:0] video_address;
    logic        line_err;
    logic        frame_err;

    always #5 clk = ~clk;

    video_window_framer #(
        .H_START  (HS),
        .H_ACTIVE (HA),
        .V_START  (VS),
        .V_ACTIVE (VA)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pix_valid         (pix_valid),
        .pix_data          (pix_data),
        .hsync             (hsync),
        .vsync             (vsync),
        .field             (field),
        .video_frame_valid (video_frame_valid),
        .video_line_valid  (video_line_valid),
        .video_data_valid  (video_data_valid),
        .video_data        (video_data),
        .video_address     (video_address),
        .line_err          (line_err),
        .frame_err         (frame_err)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic [19:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_line_err = 0;
    int   n_frame_err = 0;
    int   le0;
    int   fe0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [19:0] mk_addr(input int row, input logic f, input int col);
        return {row[8:0], f, col[9:0]};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (line_err) n_line_err++;
            if (frame_err) n_frame_err++;
            if (video_data_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pixel: got addr 0x%0h data 0x%0h, required none",
                             video_address, video_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pixel_data", 32'(video_data), 32'(mon_e.data));
                    chk("pixel_addr", 32'(video_address), 32'(mon_e.addr));
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic h, input logic pv, input logic [7:0] d,
                       input logic f);
        @(posedge clk);
        #1;
        vsync     = v;
        hsync     = h;
        pix_valid = pv;
        pix_data  = d;
        field     = f;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // pix_valid is held high on the vsync cycle: it must be discarded.
    task automatic send_vsync(input logic f);
        cyc(1'b1, 1'b0, 1'b1, 8'h55, f);
    endtask

    // One line: an hsync cycle (with a discarded pixel) then npix pixels, each followed by
    // gap idle cycles. exp_row < 0 means no output is expected from this line.
    task automatic send_line(input int exp_row, input logic f, input int npix, input int gap,
                             input logic [7:0] seed);
        logic [7:0] d;
        cyc(1'b0, 1'b1, 1'b1, 8'h66, ~f);
        for (int i = 0; i < npix; i++) begin
            d = seed + 8'(i);
            cyc(1'b0, 1'b0, 1'b1, d, ~f);
            if (exp_row >= 0 && i >= HS && i < HS + HA)
                exp_q.push_back('{data: d, addr: mk_addr(exp_row, f, i - HS)});
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 1'b0, 1'b0, 8'hEE, ~f);
                if (g == 1 && exp_row >= 0 && i == HS + 3) begin
                    @(negedge clk);
                    chk("gap_line_valid", 32'(video_line_valid), 32'd1);
                    chk("gap_data_valid", 32'(video_data_valid), 32'd0);
                    chk("gap_addr_hold", 32'(video_address), 32'(mk_addr(exp_row, f, 3)));
                    chk("gap_data_hold", 32'(video_data), 32'(d));
                end
            end
        end
    endtask

    task automatic end_field(input logic f);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, ~f);
        @(negedge clk);
        chk("frame_valid_before_end", 32'(video_frame_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h77, ~f);
        @(negedge clk);
        chk("frame_valid_after_end", 32'(video_frame_valid), 32'd0);
        chk("line_valid_after_end", 32'(video_line_valid), 32'd0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 8'h78, ~f);
        idle(3);
    endtask

    task automatic field_rows(input logic f, input int gap, input logic [7:0] s0);
        send_vsync(f);
        send_line(-1, f, 16, gap, s0);
        for (int r = 0; r < VA; r++) send_line(r, f, 16, gap, s0 + 8'(16 * (r + 1)));
        end_field(f);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_frame_valid"}, 32'(video_frame_valid), 32'd0);
        chk({tag, "_line_valid"}, 32'(video_line_valid), 32'd0);
        chk({tag, "_data_valid"}, 32'(video_data_valid), 32'd0);
        chk({tag, "_data"}, 32'(video_data), 32'd0);
        chk({tag, "_address"}, 32'(video_address), 32'd0);
        chk({tag, "_line_err"}, 32'(line_err), 32'd0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        idle(3);

        // Nominal field, then the same field with pix_valid every third cycle.
        field_rows(1'b1, 0, 8'h00);
        idle(4);
        field_rows(1'b1, 2, 8'h00);
        idle(4);
        chk("no_line_err", 32'(n_line_err), 32'd0);
        chk("no_frame_err", 32'(n_frame_err), 32'd0);

        // Short line: row 1 stops after 5 active pixels.
        le0 = n_line_err;
        send_vsync(1'b1);
        send_line(-1, 1'b1, 16, 0, 8'h20);
        send_line(0, 1'b1, 16, 0, 8'h30);
        send_line(1, 1'b1, HS + 5, 0, 8'h40);
        send_line(2, 1'b1, 16, 0, 8'h50);
        end_field(1'b1);
        chk("short_line_err_count", 32'(n_line_err - le0), 32'd1);

        // Truncated field: vsync after row 1 col 3, new field has parity 0.
        fe0 = n_frame_err;
        send_vsync(1'b1);
        send_line(-1, 1'b1, 16, 0, 8'h60);
        send_line(0, 1'b1, 16, 0, 8'h70);
        send_line(1, 1'b1, HS + 4, 0, 8'h80);
        cyc(1'b1, 1'b0, 1'b1, 8'h99, 1'b0);
        @(negedge clk);
        chk("frame_valid_at_vsync", 32'(video_frame_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 8'h98, 1'b1);
        @(negedge clk);
        chk("frame_err_pulse", 32'(frame_err), 32'd1);
        chk("frame_valid_after_trunc", 32'(video_frame_valid), 32'd0);
        chk("line_valid_after_trunc", 32'(video_line_valid), 32'd0);
        send_line(-1, 1'b0, 16, 0, 8'h90);
        for (int r = 0; r < VA; r++) send_line(r, 1'b0, 16, 0, 8'hA0 + 8'(16 * r));
        end_field(1'b0);
        chk("trunc_frame_err_count", 32'(n_frame_err - fe0), 32'd1);

        // Reset in the middle of an active line, then a partial field with no vsync.
        send_vsync(1'b1);
        send_line(-1, 1'b1, 16, 0, 8'h11);
        send_line(0, 1'b1, HS + 3, 0, 8'hB0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_line(-1, 1'b1, 16, 0, 8'hC0);
        send_line(-1, 1'b1, 16, 0, 8'hC8);
        field_rows(1'b0, 0, 8'h05);

        idle(5);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("total_line_err", 32'(n_line_err), 32'd1);
        chk("total_frame_err", 32'(n_frame_err), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
